// File: rtl/bus_pkg.sv
// Shared types and constants for the data-bus demultiplexer.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  typedef logic [1:0] tgt_sel_t;

  localparam tgt_sel_t TGT_RAM   = 2'd0;
  localparam tgt_sel_t TGT_UART  = 2'd1;
  localparam tgt_sel_t TGT_TIMER = 2'd2;
  localparam tgt_sel_t TGT_GPIO  = 2'd3;

  localparam int TIMER_W = 16;

  function automatic logic [3:0] sel_onehot(input tgt_sel_t sel);
    logic [3:0] oh;
    case (sel)
      TGT_RAM:   oh = 4'b0001;
      TGT_UART:  oh = 4'b0010;
      TGT_TIMER: oh = 4'b0100;
      TGT_GPIO:  oh = 4'b1000;
      default:   oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bus_demux4_mux4.sv
// Parameterised 4-input mux used to pick the selected target's read data.
module bus_demux4_mux4
  import bus_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  tgt_sel_t     sel,
  output logic [W-1:0] y
);

  always_comb begin
    case (sel)
      TGT_RAM:   y = d0;
      TGT_UART:  y = d1;
      TGT_TIMER: y = d2;
      TGT_GPIO:  y = d3;
      default:   y = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/bus_demux4.sv
// Routes one memory-stage request to RAM/UART/timer/GPIO by the top address
// bits and returns that target's response; a timer converts silence to an error.
module bus_demux4 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [3:0]              t_req_valid_o,
  input  logic [3:0]              t_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   t_addr_o,
  output logic                    t_we_o,
  output logic [DATA_WIDTH-1:0]   t_wdata_o,
  output logic [DATA_WIDTH/8-1:0] t_be_o,
  input  logic [3:0]              t_rsp_valid_i,
  input  logic [4*DATA_WIDTH-1:0] t_rdata_i
);
  import bus_pkg::*;

  // The timer holds the cycles already spent in REQ/RSP, so expiry fires on the
  // (TIMEOUT-1)th such cycle and the error lands TIMEOUT cycles after acceptance.
  localparam logic [TIMER_W-1:0] EXPIRE = TIMER_W'(TIMEOUT - 2);

  bus_state_t              state_r, state_s;
  tgt_sel_t                sel_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    we_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH/8-1:0] be_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic                    err_r;
  logic [TIMER_W-1:0]      timer_r;
  logic [DATA_WIDTH-1:0]   mux_rdata_s;
  logic                    accept_s, done_ok_s, done_err_s, expire_s;

  bus_demux4_mux4 #(.W(DATA_WIDTH)) u_rdata_mux (
    .d0  (t_rdata_i[0*DATA_WIDTH +: DATA_WIDTH]),
    .d1  (t_rdata_i[1*DATA_WIDTH +: DATA_WIDTH]),
    .d2  (t_rdata_i[2*DATA_WIDTH +: DATA_WIDTH]),
    .d3  (t_rdata_i[3*DATA_WIDTH +: DATA_WIDTH]),
    .sel (sel_r),
    .y   (mux_rdata_s)
  );

  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    done_ok_s  = 1'b0;
    done_err_s = 1'b0;
    expire_s   = (timer_r == EXPIRE);
    case (state_r)
      IDLE: begin
        if (req_valid_i) begin
          accept_s = 1'b1;
          state_s  = REQ;
        end else begin
          state_s  = IDLE;
        end
      end
      REQ: begin
        if (t_req_ready_i[sel_r]) begin
          state_s    = RSP;
        end else if (expire_s) begin
          done_err_s = 1'b1;
          state_s    = DONE;
        end else begin
          state_s    = REQ;
        end
      end
      RSP: begin
        // A target response on the expiry cycle takes priority over the error.
        if (t_rsp_valid_i[sel_r]) begin
          done_ok_s  = 1'b1;
          state_s    = DONE;
        end else if (expire_s) begin
          done_err_s = 1'b1;
          state_s    = DONE;
        end else begin
          state_s    = RSP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sel_r   <= TGT_RAM;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      we_r    <= 1'b0;
      wdata_r <= {DATA_WIDTH{1'b0}};
      be_r    <= {(DATA_WIDTH/8){1'b0}};
      rdata_r <= {DATA_WIDTH{1'b0}};
      err_r   <= 1'b0;
      timer_r <= {TIMER_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        sel_r   <= tgt_sel_t'(req_addr_i[ADDR_WIDTH-1 -: 2]);
        addr_r  <= req_addr_i;
        we_r    <= req_we_i;
        wdata_r <= req_wdata_i;
        be_r    <= req_be_i;
        rdata_r <= {DATA_WIDTH{1'b0}};
        err_r   <= 1'b0;
        timer_r <= {TIMER_W{1'b0}};
      end else if ((state_r == REQ || state_r == RSP) && timer_r != {TIMER_W{1'b1}}) begin
        timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
      end
      if (done_ok_s) begin
        rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : mux_rdata_s;
        err_r   <= 1'b0;
      end else if (done_err_s) begin
        rdata_r <= {DATA_WIDTH{1'b0}};
        err_r   <= 1'b1;
      end
    end
  end

  assign req_ready_o   = (state_r == IDLE);
  assign rsp_valid_o   = (state_r == DONE);
  assign rsp_rdata_o   = rdata_r;
  assign rsp_err_o     = err_r;
  assign t_req_valid_o = (state_r == REQ) ? sel_onehot(sel_r) : 4'b0000;
  assign t_addr_o      = addr_r;
  assign t_we_o        = we_r;
  assign t_wdata_o     = wdata_r;
  assign t_be_o        = be_r;

endmodule

// File: tb/tb_bus_demux4.sv
// Scoreboard bench for bus_demux4: behavioural targets with per-target wait
// and response delays; expected responses queued at acceptance.
module tb_bus_demux4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [AW-1:0]   req_addr_i = '0;
  logic            req_we_i = 1'b0;
  logic [DW-1:0]   req_wdata_i = '0;
  logic [DW/8-1:0] req_be_i = '0;
  logic            rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic [3:0]      t_req_valid_o;
  logic [3:0]      t_req_ready_i;
  logic [AW-1:0]   t_addr_o;
  logic            t_we_o;
  logic [DW-1:0]   t_wdata_o;
  logic [DW/8-1:0] t_be_o;
  logic [3:0]      t_rsp_valid_i;
  logic [4*DW-1:0] t_rdata_i;

  always #5 clk = ~clk;

  bus_demux4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .t_req_valid_o(t_req_valid_o), .t_req_ready_i(t_req_ready_i), .t_addr_o(t_addr_o),
    .t_we_o(t_we_o), .t_wdata_o(t_wdata_o), .t_be_o(t_be_o),
    .t_rsp_valid_i(t_rsp_valid_i), .t_rdata_i(t_rdata_i)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rsp_seen = 0;
  int          vcnt = 0;
  int          last_acc = 0;
  int          rdy_dly[4];
  int          rsp_dly[4];
  bit          rsp_en[4];
  logic [31:0] tdata[4];
  logic [3:0]  spur = 4'b0000;
  int          req_cnt[4];
  int          rsp_cnt[4];
  bit          pend[4];
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we;
  logic [3:0]  acc_be, acc_oh;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign t_rdata_i = {tdata[3], tdata[2], tdata[1], tdata[0]};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      t_req_ready_i[k] = t_req_valid_o[k] && (req_cnt[k] == rdy_dly[k]);
      t_rsp_valid_i[k] = (pend[k] && rsp_en[k] && (rsp_cnt[k] == rsp_dly[k])) || spur[k];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Target models: count wait cycles, then respond after rsp_dly cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        req_cnt[k] <= 0; rsp_cnt[k] <= 0; pend[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (t_req_valid_o[k]) begin
          if (t_req_ready_i[k]) begin
            pend[k] <= 1'b1; rsp_cnt[k] <= 0; req_cnt[k] <= 0;
          end else begin
            req_cnt[k] <= req_cnt[k] + 1; pend[k] <= 1'b0;
          end
        end else begin
          req_cnt[k] <= 0;
          if (pend[k]) begin
            if (t_rsp_valid_i[k]) pend[k] <= 1'b0;
            else rsp_cnt[k] <= rsp_cnt[k] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid_o) begin
        rsp_seen <= rsp_seen + 1;
        check("t_req_valid_in_done", t_req_valid_o, 4'b0000);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata_o, mon_e.rdata);
          check("rsp_err", rsp_err_o, mon_e.err);
          check("rsp_cycle", cyc, mon_e.cyc);
        end
      end
      if (t_req_valid_o != 4'b0000) begin
        vcnt <= vcnt + 1;
        check("t_req_valid_onehot", t_req_valid_o, acc_oh);
        check("t_addr", t_addr_o, acc_addr);
        check("t_we", t_we_o, acc_we);
        check("t_wdata", t_wdata_o, acc_wdata);
        check("t_be", t_be_o, acc_be);
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] er, input logic ee,
                      input int lat, input bit hold, input int gap);
    bit         got;
    exp_t       e;
    logic [1:0] s;
    req_addr_i  = addr;
    req_we_i    = we;
    req_wdata_i = wd;
    req_be_i    = be;
    req_valid_i = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req_ready_o) begin
        got = 1'b1;
        e.rdata = er; e.err = ee; e.cyc = cyc + lat;
        exp_q.push_back(e);
        acc_addr = addr; acc_we = we; acc_wdata = wd; acc_be = be;
        s = addr[31:30];
        acc_oh = 4'b0001 << s;
        if (gap > 0) check("accept_gap", cyc - last_acc, gap);
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!got) check("accept_timeout", 1'b0, 1'b1);
    if (!hold) req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(posedge clk);
    if (exp_q.size() != 0) check("rsp_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int v0, r0;
    for (int k = 0; k < 4; k++) begin
      rdy_dly[k] = 0; rsp_dly[k] = 0; rsp_en[k] = 1'b1;
    end
    tdata[0] = 32'hDEAD_BEEF; tdata[1] = 32'h5A5A_0001;
    tdata[2] = 32'h7777_0002; tdata[3] = 32'h0000_1234;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready_o, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_t_req_valid", t_req_valid_o, 4'b0000);
    check("rst_rsp_err", rsp_err_o, 1'b0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check("rst_t_addr", t_addr_o, 32'h0);
    check("rst_t_wdata", {t_we_o, t_be_o, t_wdata_o}, 37'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait RAM read
    send(32'h0000_0010, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 0);
    wait_done();

    // GPIO write, ready after 3 wait cycles; target data must be masked
    rdy_dly[3] = 3;
    v0 = vcnt;
    send(32'hC000_0004, 1'b1, 32'h0000_00A5, 4'b0001, 32'h0, 1'b0, 6, 1'b0, 0);
    wait_done();
    check("gpio_valid_cycles", vcnt - v0, 4);
    rdy_dly[3] = 0;

    // UART accepts but never answers: error from RSP
    rsp_en[1] = 1'b0;
    send(32'h4000_0000, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, TO, 1'b0, 0);
    wait_done();
    rsp_en[1] = 1'b1;

    // timer never ready: error from REQ, request valid dropped
    rdy_dly[2] = 100;
    v0 = vcnt;
    send(32'h8000_0008, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, TO, 1'b0, 0);
    wait_done();
    check("timer_valid_cycles", vcnt - v0, TO - 1);
    rdy_dly[2] = 0;

    // UART answers on the expiry cycle; spurious responses from targets 0 and 2
    rsp_dly[1] = 5;
    spur = 4'b0101;
    send(32'h4000_0010, 1'b0, 32'h0, 4'hF, 32'h5A5A_0001, 1'b0, TO, 1'b0, 0);
    wait_done();
    spur = 4'b0000;
    rsp_dly[1] = 0;

    // back-to-back reads with req_valid held high
    send(32'h0000_0100, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3, 1'b1, 0);
    send(32'h4000_0100, 1'b0, 32'h0, 4'hF, 32'h5A5A_0001, 1'b0, 3, 1'b1, 4);
    send(32'h8000_0100, 1'b0, 32'h0, 4'hF, 32'h7777_0002, 1'b0, 3, 1'b1, 4);
    send(32'hC000_0100, 1'b0, 32'h0, 4'hF, 32'h0000_1234, 1'b0, 3, 1'b0, 4);
    wait_done();

    // reset while in REQ discards the transaction
    rdy_dly[0] = 6;
    send(32'h0000_0020, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_t_req_valid", t_req_valid_o, 4'b0000);
    check("midrst_req_ready", req_ready_o, 1'b1);
    check("midrst_rsp_valid", rsp_valid_o, 1'b0);
    exp_q.delete();
    r0 = rsp_seen;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rdy_dly[0] = 0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_rsp", rsp_seen - r0, 0);
    check("midrst_ready_after", req_ready_o, 1'b1);

    tdata[0] = 32'h0BAD_F00D;
    send(32'h0000_0030, 1'b0, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 3, 1'b0, 0);
    wait_done();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
